// File: rtl/dmac_cfg_pkg.sv
// Shared register map, reset constants and per-channel config type for the
// multi-channel DMA configuration block.
package dmac_cfg_pkg;

    localparam logic [11:0] VERSION_OFF  = 12'h000;
    localparam logic [11:0] IRQ_STAT_OFF = 12'h004;
    localparam logic [11:0] IRQ_EN_OFF   = 12'h008;
    localparam logic [11:0] CH_BASE      = 12'h100;
    localparam logic [11:0] CH_STRIDE    = 12'h020;

    localparam logic [4:0] SRC_OFF  = 5'h00;
    localparam logic [4:0] DST_OFF  = 5'h04;
    localparam logic [4:0] LEN_OFF  = 5'h08;
    localparam logic [4:0] CMD_OFF  = 5'h0C;
    localparam logic [4:0] STAT_OFF = 5'h10;

    localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0101;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } ch_cfg_t;

    function automatic logic ch_off_mapped(input logic [4:0] off);
        logic hit;
        case (off)
            SRC_OFF, DST_OFF, LEN_OFF, CMD_OFF, STAT_OFF: hit = 1'b1;
            default:                                      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/dmac_ch_regs.sv
// One DMA channel's SRC/DST/LEN registers, busy flag and done edge detector.
// Write strobes arrive already qualified (decode, error and busy checks) by the top.
module dmac_ch_regs
    import dmac_cfg_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_src,
    input  logic             wr_dst,
    input  logic             wr_len,
    input  logic             wr_cmd,
    input  logic [31:0]      wdata,
    input  logic             done,
    input  logic [4:0]       roff,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             start,
    output logic             rise,
    output logic [31:0]      rdata
);

    // Upper length bits are never written, so the full field always reads back zero-extended.
    localparam logic [31:0] LEN_MASK = 32'hFFFF_FFFF >> (32 - LEN_W);

    ch_cfg_t cfg_r;
    logic    busy_r;
    logic    done_d_r;

    assign start = wr_cmd & wdata[0] & ~busy_r;
    assign rise  = done & ~done_d_r;
    assign src   = cfg_r.src;
    assign dst   = cfg_r.dst;
    assign len   = cfg_r.len[LEN_W-1:0];
    assign busy  = busy_r;

    // Config registers, busy tracking (start beats a coincident done) and done delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_r    <= '{src: 32'd0, dst: 32'd0, len: 32'd0};
            busy_r   <= 1'b0;
            done_d_r <= 1'b0;
        end else begin
            if (wr_src) cfg_r.src <= wdata;
            if (wr_dst) cfg_r.dst <= wdata;
            if (wr_len) cfg_r.len <= wdata & LEN_MASK;
            if (start) begin
                busy_r <= 1'b1;
            end else if (rise) begin
                busy_r <= 1'b0;
            end
            done_d_r <= done;
        end
    end

    // Channel-local read data; CMD is write-only and reads as zero.
    always_comb begin
        rdata = 32'd0;
        case (roff)
            SRC_OFF:  rdata = cfg_r.src;
            DST_OFF:  rdata = cfg_r.dst;
            LEN_OFF:  rdata = cfg_r.len;
            STAT_OFF: rdata = {30'd0, busy_r, done};
            default:  rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmac_mch_cfg.sv
// APB configuration/status block for an N_CH-channel DMA controller: address
// decode, error response, W1C interrupt status with enable mask and level IRQ.
module dmac_mch_cfg
    import dmac_cfg_pkg::*;
#(
    parameter int          N_CH    = 4,
    parameter int          LEN_W   = 16,
    parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic [11:0]           paddr_i,
    input  logic                  pwrite_i,
    input  logic [31:0]           pwdata_i,
    output logic                  pready_o,
    output logic [31:0]           prdata_o,
    output logic                  pslverr_o,
    output logic [N_CH*32-1:0]    src_addr_o,
    output logic [N_CH*32-1:0]    dst_addr_o,
    output logic [N_CH*LEN_W-1:0] byte_len_o,
    output logic [N_CH-1:0]       start_o,
    input  logic [N_CH-1:0]       done_i,
    output logic                  irq_o
);

    localparam int         CH_SHIFT = $clog2(int'(CH_STRIDE));
    localparam logic [3:0] N_CH_L   = 4'(N_CH);

    logic            acc_s, wren_s, rd_setup_s;
    logic [11:0]     ch_rel_s;
    logic [2:0]      ch_idx_s;
    logic [4:0]      ch_off_s;
    logic            in_ch_s, ch_valid_s;
    logic            hit_ver_s, hit_stat_s, hit_en_s, mapped_s, ro_s, prot_s;
    logic            sel_busy_s, err_s, wr_ok_s;
    logic [N_CH-1:0] wr_src_s, wr_dst_s, wr_len_s, wr_cmd_s, busy_s, rise_s;
    logic [31:0]     ch_rdata_s [N_CH];
    logic [31:0]     rd_mux_s;
    logic [N_CH-1:0] irq_stat_nxt_s, irq_en_nxt_s;
    logic [N_CH-1:0] irq_stat_r, irq_en_r;
    logic [31:0]     prdata_r;
    logic            irq_r;

    assign acc_s      = psel_i & penable_i;
    assign wren_s     = acc_s & pwrite_i;
    assign rd_setup_s = psel_i & ~penable_i & ~pwrite_i;

    // Address decode, APB error classification and per-channel write strobes.
    always_comb begin
        ch_rel_s   = paddr_i - CH_BASE;
        in_ch_s    = (paddr_i[11:8] == CH_BASE[11:8]);
        ch_idx_s   = 3'(ch_rel_s >> CH_SHIFT);
        ch_off_s   = ch_rel_s[4:0];
        ch_valid_s = in_ch_s && ({1'b0, ch_idx_s} < N_CH_L) && ch_off_mapped(ch_off_s);
        hit_ver_s  = (paddr_i == VERSION_OFF);
        hit_stat_s = (paddr_i == IRQ_STAT_OFF);
        hit_en_s   = (paddr_i == IRQ_EN_OFF);
        mapped_s   = hit_ver_s | hit_stat_s | hit_en_s | ch_valid_s;
        ro_s       = hit_ver_s | (ch_valid_s & (ch_off_s == STAT_OFF));
        prot_s     = ch_valid_s & ((ch_off_s == SRC_OFF) | (ch_off_s == DST_OFF) |
                     (ch_off_s == LEN_OFF) | ((ch_off_s == CMD_OFF) & pwdata_i[0]));
        sel_busy_s = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx_s == 3'(c)) begin
                sel_busy_s = busy_s[c];
            end else begin
                sel_busy_s = sel_busy_s;
            end
        end
        err_s   = acc_s & (~mapped_s | (pwrite_i & ro_s) | (pwrite_i & prot_s & sel_busy_s));
        wr_ok_s = wren_s & ~err_s;
        for (int c = 0; c < N_CH; c++) begin
            wr_src_s[c] = wr_ok_s & ch_valid_s & (ch_idx_s == 3'(c)) & (ch_off_s == SRC_OFF);
            wr_dst_s[c] = wr_ok_s & ch_valid_s & (ch_idx_s == 3'(c)) & (ch_off_s == DST_OFF);
            wr_len_s[c] = wr_ok_s & ch_valid_s & (ch_idx_s == 3'(c)) & (ch_off_s == LEN_OFF);
            wr_cmd_s[c] = wr_ok_s & ch_valid_s & (ch_idx_s == 3'(c)) & (ch_off_s == CMD_OFF);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        dmac_ch_regs #(.LEN_W(LEN_W)) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_src (wr_src_s[c]),
            .wr_dst (wr_dst_s[c]),
            .wr_len (wr_len_s[c]),
            .wr_cmd (wr_cmd_s[c]),
            .wdata  (pwdata_i),
            .done   (done_i[c]),
            .roff   (ch_off_s),
            .src    (src_addr_o[c*32 +: 32]),
            .dst    (dst_addr_o[c*32 +: 32]),
            .len    (byte_len_o[c*LEN_W +: LEN_W]),
            .busy   (busy_s[c]),
            .start  (start_o[c]),
            .rise   (rise_s[c]),
            .rdata  (ch_rdata_s[c])
        );
    end

    // Read mux; anything unmapped returns zero.
    always_comb begin
        rd_mux_s = 32'd0;
        if (hit_ver_s) begin
            rd_mux_s = VERSION;
        end else if (hit_stat_s) begin
            rd_mux_s[N_CH-1:0] = irq_stat_r;
        end else if (hit_en_s) begin
            rd_mux_s[N_CH-1:0] = irq_en_r;
        end else if (ch_valid_s) begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_idx_s == 3'(c)) begin
                    rd_mux_s = ch_rdata_s[c];
                end else begin
                    rd_mux_s = rd_mux_s;
                end
            end
        end else begin
            rd_mux_s = 32'd0;
        end
    end

    // Interrupt next-state: a done rise overrides a same-cycle W1C of that bit.
    always_comb begin
        if (wr_ok_s && hit_stat_s) begin
            irq_stat_nxt_s = (irq_stat_r & ~pwdata_i[N_CH-1:0]) | rise_s;
        end else begin
            irq_stat_nxt_s = irq_stat_r | rise_s;
        end
        if (wr_ok_s && hit_en_s) begin
            irq_en_nxt_s = pwdata_i[N_CH-1:0];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
    end

    // Interrupt state, IRQ line and read data capture in the SETUP phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_stat_r <= {N_CH{1'b0}};
            irq_en_r   <= {N_CH{1'b0}};
            irq_r      <= 1'b0;
            prdata_r   <= 32'd0;
        end else begin
            irq_stat_r <= irq_stat_nxt_s;
            irq_en_r   <= irq_en_nxt_s;
            irq_r      <= |(irq_stat_nxt_s & irq_en_nxt_s);
            if (rd_setup_s) begin
                prdata_r <= rd_mux_s;
            end
        end
    end

    assign pready_o  = 1'b1;
    assign pslverr_o = err_s;
    assign prdata_o  = prdata_r;
    assign irq_o     = irq_r;

endmodule
